ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand-forwarding front end of the execute stage.
//  Captures one decoded instruction, resolves RAW hazards from MEM and WB, and drives
//  a/b/ALU_Sel straight into the ALU (combinational ADD..SRA, sel 0-9).
//  Holds the instruction under downstream backpressure or a load-use hazard.
//  A flush from branch resolution discards the held instruction.
// PARAMETERS
//  XLEN    32  datapath width
//  AW      5   register-address width
//  FWD_EN  1   1 = MEM/WB forwarding on; 0 = no forwarding, no load-use hold
// PORTS
//  clk            in   1     single clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush          in   1     kill held instruction and any instruction accepted this cycle
//  id_valid       in   1     decode presents an instruction
//  id_ready       out  1     stage can accept
//  id_rs1_addr    in   AW    source register 1
//  id_rs2_addr    in   AW    source register 2
//  id_rs1_data    in   XLEN  regfile read 1
//  id_rs2_data    in   XLEN  regfile read 2
//  id_pc          in   XLEN  instruction PC
//  id_imm         in   XLEN  sign-extended immediate
//  id_use_pc      in   1     a = pc instead of rs1
//  id_use_imm     in   1     b = imm instead of rs2
//  id_alu_sel     in   4     ALU op code, 0-9
//  id_rd_addr     in   AW    destination register
//  id_reg_write   in   1     instruction writes rd
//  mem_rd_addr    in   AW    EX/MEM destination register
//  mem_reg_write  in   1     EX/MEM writes rd
//  mem_is_load    in   1     EX/MEM is a load (result not yet available)
//  mem_result     in   XLEN  EX/MEM ALU result
//  wb_rd_addr     in   AW    MEM/WB destination register
//  wb_reg_write   in   1     MEM/WB writes rd
//  wb_result      in   XLEN  MEM/WB writeback value
//  ex_valid       out  1     a/b/sel valid for the ALU
//  ex_ready       in   1     downstream accepts
//  ex_a           out  XLEN  ALU operand a
//  ex_b           out  XLEN  ALU operand b
//  ex_alu_sel     out  4     ALU op code
//  ex_rd_addr     out  AW    destination register, passed through
//  ex_reg_write   out  1     write enable, passed through
//  ex_illegal     out  1     held alu_sel > 9; ALU would output DEADBEEF
// BEHAVIOUR
//  Reset: occupied=0. All registers 0, so ex_valid=0, ex_a=ex_b=0, ex_alu_sel=0,
//   ex_rd_addr=0, ex_reg_write=0, ex_illegal=0.
//  Reset is asynchronous and acts mid-operation: the held instruction is dropped.
//  id_ready = !occupied | (ex_valid & ex_ready), combinational.
//  Accept when id_valid & id_ready: capture a_q=use_pc?pc:rs1_data and
//   b_q=use_imm?imm:rs2_data, plus addresses, use flags, sel, rd and reg_write.
//   Latency is 1 cycle from accept to ex_valid.
//  Forward for a (and likewise b): only when use flag=0 and src!=0.
//   MEM hit = mem_reg_write & mem_rd==src. WB hit = wb_reg_write & wb_rd==src.
//   MEM wins over WB. A non-load MEM hit supplies mem_result. Otherwise a WB hit
//   supplies wb_result. Otherwise the output is a_q.
//  Register x0 is never forwarded and never causes a hold.
//  Load-use hold: a MEM hit with mem_is_load forces ex_valid=0 and id_ready=0.
//  ex_valid = occupied & !load_hold.
//  Refresh: each cycle occupied & !(ex_valid & ex_ready), a/b_q <= forwarded value.
//   This keeps the operand correct after the producer retires during a long stall.
//  Departure: ex_valid & ex_ready with no new accept -> occupied <= 0.
//   Simultaneous departure and accept -> new instruction loaded, occupied stays 1.
//  flush: occupied <= 0 next edge. Overrides accept and refresh; id_ready is unaffected.
//  FWD_EN=0: outputs are always a_q/b_q, no hold, no refresh.
//  Operands pass unmodified; width is XLEN throughout; no arithmetic in this block.
// TESTING
//  Accept: rs1=5, rs2=7, sel=0, no hazards -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_alu_sel=0.
//  Forward: held src1=x3, mem_rd=3 result 0x10 and wb_rd=3 result 0x20 -> ex_a=0x10; drop MEM -> ex_a=0x20.
//  Load-use: held src2=x4, mem_is_load with mem_rd=4 -> ex_valid=0, id_ready=0;
//   next cycle wb_rd=4 result 0x99 -> ex_valid=1, ex_b=0x99.
//  Stall refresh: ex_ready=0 for 3 cycles with WB forward of 0xAB then WB idle -> ex_b stays 0xAB.
//  x0/imm: src1=x0 with mem_rd=0 write -> ex_a=rs1_data. use_imm=1, imm=-4 -> ex_b=0xFFFFFFFC.
//  Flush/reset: flush with id_valid=1 -> next cycle ex_valid=0. rst_n low mid-stall -> all outputs 0 at once.
//   sel=12 accepted -> ex_illegal=1.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hold.
// Drives ALU operands and op code; holds under backpressure, drops on flush.
module ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1_addr,
  input  logic [AW-1:0]   id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  logic [3:0]      id_alu_sel,
  input  logic [AW-1:0]   id_rd_addr,
  input  logic            id_reg_write,
  input  logic [AW-1:0]   mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_result,
  input  logic [AW-1:0]   wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_sel,
  output logic [AW-1:0]   ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  logic            occupied_q, occupied_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            use_pc_q, use_pc_d, use_imm_q, use_imm_d, rw_q, rw_d;
  logic [3:0]      sel_q, sel_d;

  logic            mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic            load_hold, accept, depart;

  // x0 and pc/imm operands never match a producer.
  always_comb begin
    mem_hit_a = FWD_EN && !use_pc_q && (rs1_q != '0) && mem_reg_write && (mem_rd_addr == rs1_q);
    mem_hit_b = FWD_EN && !use_imm_q && (rs2_q != '0) && mem_reg_write && (mem_rd_addr == rs2_q);
    wb_hit_a  = FWD_EN && !use_pc_q && (rs1_q != '0) && wb_reg_write && (wb_rd_addr == rs1_q);
    wb_hit_b  = FWD_EN && !use_imm_q && (rs2_q != '0) && wb_reg_write && (wb_rd_addr == rs2_q);

    fwd_a = a_q;
    if (mem_hit_a) begin
      if (!mem_is_load) fwd_a = mem_result;
    end else if (wb_hit_a) begin
      fwd_a = wb_result;
    end

    fwd_b = b_q;
    if (mem_hit_b) begin
      if (!mem_is_load) fwd_b = mem_result;
    end else if (wb_hit_b) begin
      fwd_b = wb_result;
    end

    load_hold = occupied_q && mem_is_load && (mem_hit_a || mem_hit_b);
    ex_valid  = occupied_q && !load_hold;
    id_ready  = !occupied_q || (ex_valid && ex_ready);
    accept    = id_valid && id_ready;
    depart    = ex_valid && ex_ready;
  end

  always_comb begin
    occupied_d = occupied_q;
    a_d        = a_q;
    b_d        = b_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    use_pc_d   = use_pc_q;
    use_imm_d  = use_imm_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    if (flush) begin
      occupied_d = 1'b0;
    end else if (accept) begin
      occupied_d = 1'b1;
      a_d        = id_use_pc ? id_pc : id_rs1_data;
      b_d        = id_use_imm ? id_imm : id_rs2_data;
      rs1_d      = id_rs1_addr;
      rs2_d      = id_rs2_addr;
      use_pc_d   = id_use_pc;
      use_imm_d  = id_use_imm;
      sel_d      = id_alu_sel;
      rd_d       = id_rd_addr;
      rw_d       = id_reg_write;
    end else if (depart) begin
      occupied_d = 1'b0;
    end else if (occupied_q && FWD_EN) begin
      // Capture forwarded values so a producer retiring mid-stall is not lost.
      a_d = fwd_a;
      b_d = fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      use_pc_q   <= 1'b0;
      use_imm_q  <= 1'b0;
      sel_q      <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
    end else begin
      occupied_q <= occupied_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      use_pc_q   <= use_pc_d;
      use_imm_q  <= use_imm_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
    end
  end

  assign ex_a         = fwd_a;
  assign ex_b         = fwd_b;
  assign ex_alu_sel   = sel_q;
  assign ex_rd_addr   = rd_q;
  assign ex_reg_write = rw_q;
  assign ex_illegal   = (sel_q > 4'd9);

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected departures queued by stimulus,
// popped by a monitor on each ex_valid & ex_ready handshake.
module tb_ex_operand_stage;

  logic        clk, rst_n, flush, id_valid, id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr, wb_rd_addr, ex_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_pc, id_imm, mem_result, wb_result, ex_a, ex_b;
  logic        id_use_pc, id_use_imm, id_reg_write, mem_reg_write, mem_is_load, wb_reg_write;
  logic [3:0]  id_alu_sel, ex_alu_sel;
  logic        ex_valid, ex_ready, ex_reg_write, ex_illegal;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  ex_operand_stage #(.XLEN(32), .AW(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_pc(id_pc), .id_imm(id_imm), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_alu_sel(id_alu_sel), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .wb_result(wb_result), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_sel(ex_alu_sel), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst_n && ex_valid && ex_ready) begin
        got = '{a: ex_a, b: ex_b, sel: ex_alu_sel, rd: ex_rd_addr, rw: ex_reg_write,
                ill: ex_illegal};
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_output: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            nerr++;
            $display("FAIL departure: got a=%h b=%h sel=%0d rd=%0d rw=%b ill=%b expected a=%h b=%h sel=%0d rd=%0d rw=%b ill=%b",
                     got.a, got.b, got.sel, got.rd, got.rw, got.ill,
                     e.a, e.b, e.sel, e.rd, e.rw, e.ill);
          end
        end
      end
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                      input logic [4:0] rd, input logic ill);
    exp_q.push_back('{a: a, b: b, sel: sel, rd: rd, rw: 1'b1, ill: ill});
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] pc, input logic [31:0] imm,
                       input logic upc, input logic uimm, input logic [3:0] sel,
                       input logic [4:0] rd);
    id_rs1_addr = r1;  id_rs2_addr = r2;  id_rs1_data = d1;  id_rs2_data = d2;
    id_pc = pc;        id_imm = imm;      id_use_pc = upc;   id_use_imm = uimm;
    id_alu_sel = sel;  id_rd_addr = rd;   id_reg_write = 1'b1;
    id_valid = 1'b1;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 1'b0; mem_is_load = 1'b0; wb_reg_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_data = '0; id_rs2_data = '0;
    id_pc = '0; id_imm = '0; id_use_pc = 1'b0; id_use_imm = 1'b0;
    id_alu_sel = '0; id_rd_addr = '0; id_reg_write = 1'b0;
    mem_rd_addr = '0; mem_result = '0; wb_rd_addr = '0; wb_result = '0;
    clear_fwd();
    fork
      monitor();
    join_none

    // Reset state
    @(negedge clk);
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_ex_a", ex_a, 32'd0);
    check("rst_ex_b", ex_b, 32'd0);
    check("rst_misc", {22'b0, ex_alu_sel, ex_rd_addr, ex_reg_write}, 32'd0);
    check("rst_id_ready", {31'b0, id_ready}, 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain accept
    push(32'd5, 32'd7, 4'd0, 5'd8, 1'b0);
    issue(5'd1, 5'd2, 32'd5, 32'd7, 32'h100, 32'd0, 1'b0, 1'b0, 4'd0, 5'd8);
    @(posedge clk); #1;

    // MEM beats WB, then WB alone, then refreshed value survives WB going idle
    ex_ready = 1'b0;
    issue(5'd3, 5'd0, 32'h111, 32'h222, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1, 5'd9);
    mem_rd_addr = 5'd3; mem_reg_write = 1'b1; mem_result = 32'h10;
    wb_rd_addr = 5'd3; wb_reg_write = 1'b1; wb_result = 32'h20;
    @(negedge clk);
    check("fwd_mem_wins", ex_a, 32'h10);
    @(posedge clk); #1;
    mem_reg_write = 1'b0;
    @(negedge clk);
    check("fwd_wb", ex_a, 32'h20);
    @(posedge clk); #1;
    wb_reg_write = 1'b0;
    push(32'h20, 32'h222, 4'd1, 5'd9, 1'b0);
    ex_ready = 1'b1;
    @(posedge clk); #1;

    // Load-use hold, resolved by WB
    mem_rd_addr = 5'd4; mem_reg_write = 1'b1; mem_is_load = 1'b1; mem_result = 32'hDEAD;
    issue(5'd0, 5'd4, 32'd1, 32'h444, 32'h0, 32'h0, 1'b0, 1'b0, 4'd2, 5'd10);
    @(negedge clk);
    check("load_hold_valid", {31'b0, ex_valid}, 32'd0);
    check("load_hold_ready", {31'b0, id_ready}, 32'd0);
    @(posedge clk); #1;
    clear_fwd();
    wb_rd_addr = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h99;
    push(32'd1, 32'h99, 4'd2, 5'd10, 1'b0);
    @(posedge clk); #1;
    clear_fwd();

    // Stall refresh: WB value captured while stalled
    ex_ready = 1'b0;
    issue(5'd0, 5'd6, 32'd0, 32'h666, 32'h0, 32'h0, 1'b0, 1'b0, 4'd5, 5'd11);
    wb_rd_addr = 5'd6; wb_reg_write = 1'b1; wb_result = 32'hAB;
    @(negedge clk);
    check("stall_b_0", ex_b, 32'hAB);
    @(posedge clk); #1;
    wb_reg_write = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_b_%0d", i), ex_b, 32'hAB);
      @(posedge clk); #1;
    end
    push(32'd0, 32'hAB, 4'd5, 5'd11, 1'b0);
    ex_ready = 1'b1;
    @(posedge clk); #1;

    // x0 never forwarded nor held; imm and pc selection; back-to-back accepts
    mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h555;
    push(32'h1234, 32'hFFFF_FFFC, 4'd1, 5'd12, 1'b0);
    issue(5'd0, 5'd0, 32'h1234, 32'h777, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 4'd1, 5'd12);
    mem_is_load = 1'b1;
    push(32'h2222, 32'h3333, 4'd3, 5'd13, 1'b0);
    issue(5'd0, 5'd0, 32'h2222, 32'h3333, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3, 5'd13);
    mem_rd_addr = 5'd5; mem_is_load = 1'b0;
    push(32'h8000_0000, 32'h33, 4'd6, 5'd14, 1'b0);
    issue(5'd5, 5'd0, 32'h5, 32'h33, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 4'd6, 5'd14);
    clear_fwd();
    @(posedge clk); #1;

    // Flush on accept, then flush of a held instruction
    flush = 1'b1;
    issue(5'd1, 5'd2, 32'h9, 32'h9, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 5'd1);
    flush = 1'b0;
    @(negedge clk);
    check("flush_accept", {31'b0, ex_valid}, 32'd0);
    @(posedge clk); #1;
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 32'h9, 32'h9, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 5'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    check("flush_held", {31'b0, ex_valid}, 32'd0);
    check("flush_ready", {31'b0, id_ready}, 32'd1);
    @(posedge clk); #1;

    // Illegal op code
    push(32'd0, 32'd0, 4'd12, 5'd15, 1'b1);
    issue(5'd0, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd12, 5'd15);
    @(posedge clk); #1;

    // Asynchronous reset while stalled
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 32'h42, 32'h43, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3, 5'd7);
    @(negedge clk);
    check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, ex_valid}, 32'd0);
    check("arst_a", ex_a, 32'd0);
    check("arst_b", ex_b, 32'd0);
    check("arst_misc", {21'b0, ex_alu_sel, ex_rd_addr, ex_reg_write, ex_illegal}, 32'd0);
    #1 rst_n = 1'b1;
    ex_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_valid", {31'b0, ex_valid}, 32'd0);

    // Drain: every queued departure must have been observed
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
